// File: rtl/dm_pkg.sv
// Shared types for the data memory block: access size codes and FSM states.
// Optional store trace: define DM_TRACE_EN.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_IDLE  = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  function automatic logic size_ok(input logic [1:0] sz);
    return sz != SZ_ILL;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane merge for stores and extraction/extension for loads.
// Purely combinational; illegal size is flagged by the caller.
import dm_pkg::*;

module dm_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        is_signed,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load,
  output logic        misalign
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsel = old_word[{addr, 3'b000} +: 8];
  assign hsel = old_word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    merged   = old_word;
    load     = '0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        merged[{addr, 3'b000} +: 8] = wdata[7:0];
        load = {{24{is_signed & bsel[7]}}, bsel};
      end
      SZ_HALF: begin
        misalign = addr[0];
        merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        load = {{16{is_signed & hsel[15]}}, hsel};
      end
      SZ_WORD: begin
        misalign = addr != 2'b00;
        merged   = wdata;
        load     = old_word;
      end
      default: begin
        merged   = old_word;
        load     = '0;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data memory with valid/ready requests, fixed read latency and a
// zero-walk after reset. Store trace enabled by defining DM_TRACE_EN.
import dm_pkg::*;

module dm_ctrl #(
  parameter int DEPTH_WORDS    = 2048,
  parameter int ADDR_W         = 32,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [IW-1:0] LAST = IW'(DEPTH_WORDS - 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam state_t RST_STATE =
    (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state;
  logic [IW-1:0] clr_idx;
  logic [3:0]    cnt;

  logic [IW-1:0] widx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   load;
  logic          misalign;
  logic          oor;
  logic          err;
  logic          accept;
  logic          do_store;

  assign widx     = req_addr[IW+1:2];
  assign old_word = mem[widx];
  // any address bit at or above the array span is out of range
  assign oor      = |(req_addr >> (IW + 2));
  assign err      = oor | misalign | !size_ok(req_size);
  assign accept   = req_valid && req_ready;
  assign do_store = accept && req_we && !err;

  assign req_ready = state == S_IDLE;
  assign busy      = state != S_IDLE;

  dm_lane_align u_align (
    .size      (req_size),
    .addr      (req_addr[1:0]),
    .is_signed (req_signed),
    .old_word  (old_word),
    .wdata     (req_wdata),
    .merged    (merged),
    .load      (load),
    .misalign  (misalign)
  );

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_store && !reset) begin
      mem[widx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_STATE;
      clr_idx    <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST)
            state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            resp_rdata <= (err || req_we) ? '0 : load;
            resp_err   <= err;
            if (LATENCY == 1) begin
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state      <= S_IDLE;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && do_store)
      $display("@%h: *%h <= %h", req_pc,
               {req_addr[ADDR_W-1:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench: two instances (latency 1 and 3) sharing request fields,
// reset and clock, each with its own req_valid.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v1 = 1'b0;
  logic        v3 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;

  logic        rdy1, rv1, err1, busy1;
  logic [31:0] rd1;
  logic        rdy3, rv3, err3, busy3;
  logic [31:0] rd3;

  int          sel = 1;
  logic        s_ready, s_rvalid, s_err;
  logic [31:0] s_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    s_ready  = (sel == 3) ? rdy3 : rdy1;
    s_rvalid = (sel == 3) ? rv3 : rv1;
    s_err    = (sel == 3) ? err3 : err1;
    s_rdata  = (sel == 3) ? rd3 : rd1;
  end

  dm_ctrl #(.DEPTH_WORDS(16), .ADDR_W(32), .LATENCY(1),
            .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1)
  );

  dm_ctrl #(.DEPTH_WORDS(16), .ADDR_W(32), .LATENCY(3),
            .CLEAR_ON_RESET(1)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .busy(busy3)
  );

  task automatic xact(input int which, input logic we,
                      input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(posedge clk); #1;
    sel = which;
    req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_pc = 32'h1000 + a;
    if (which == 3) v3 = 1'b1; else v1 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin n++; @(negedge clk); end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h got ready=0 want=1", a);
    end
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s_rvalid && lat < 40);
    if (!s_rvalid) begin
      total++; bad++;
      $display("FAIL resp_timeout addr=%h got valid=0 want=1", a);
    end
    rd = s_rdata; er = s_err;
  endtask

  task automatic test_reset;
    int n;
    logic [31:0] rd; logic er; int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rdy3, rv3, err3, busy3, rd3} !== {4'b0001, 32'h0}) begin
      bad++;
      $display("FAIL reset_outputs got=%b_%h want=0001_00000000",
               {rdy3, rv3, err3, busy3}, rd3);
    end
    @(posedge clk); #1 reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rdy3 && n < 100) begin n++; @(negedge clk); end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL clear_cycles got=%0d want=16", n);
    end
    total++;
    if ({rdy1, busy1} !== 2'b10) begin
      bad++; $display("FAIL idle_flags got=%b want=10", {rdy1, busy1});
    end
    xact(1, 0, 2'b10, 0, 32'h3C, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL lw_3c_cleared got=%h want=00000000", rd);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    logic [31:0] want [7];
    logic [31:0] got [7];
    xact(1, 1, 2'b10, 0, 32'h8, 32'h11223344, rd, er, lat);
    total++;
    if ({er, rd} !== 33'h0) begin
      bad++; $display("FAIL sw_resp got=%b_%h want=0_00000000", er, rd);
    end
    xact(1, 1, 2'b00, 0, 32'h9, 32'hFFFFFFAA, rd, er, lat);
    xact(1, 1, 2'b01, 0, 32'h12, 32'h1234BEEF, rd, er, lat);
    want = '{32'h1122AA44, 32'hFFFFFFAA, 32'h000000AA, 32'h00001122,
             32'hFFFFAA44, 32'h0000AA44, 32'hBEEF0000};
    xact(1, 0, 2'b10, 0, 32'h8, 0, got[0], er, lat);
    xact(1, 0, 2'b00, 1, 32'h9, 0, got[1], er, lat);
    xact(1, 0, 2'b00, 0, 32'h9, 0, got[2], er, lat);
    xact(1, 0, 2'b01, 1, 32'hA, 0, got[3], er, lat);
    xact(1, 0, 2'b01, 1, 32'h8, 0, got[4], er, lat);
    xact(1, 0, 2'b01, 0, 32'h8, 0, got[5], er, lat);
    xact(1, 0, 2'b10, 1, 32'h10, 0, got[6], er, lat);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL load_%0d got=%h want=%h", i, got[i], want[i]);
      end
    end
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL lat1 got=%0d want=1", lat);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    logic [31:0] a [4];
    logic [1:0]  s [4];
    logic        w [4];
    xact(1, 1, 2'b10, 0, 32'h4, 32'hCAFEF00D, rd, er, lat);
    xact(1, 1, 2'b10, 0, 32'h0, 32'h5A5A5A5A, rd, er, lat);
    a = '{32'h5, 32'h6, 32'h4, 32'h40};
    s = '{2'b01, 2'b10, 2'b11, 2'b10};
    w = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      xact(1, w[i], s[i], 1, a[i], 32'hFFFFFFFF, rd, er, lat);
      total++;
      if ({er, rd} !== {1'b1, 32'h0}) begin
        bad++;
        $display("FAIL err_%0d got=%b_%h want=1_00000000", i, er, rd);
      end
    end
    xact(1, 0, 2'b10, 0, 32'h4, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin
      bad++; $display("FAIL err_word4 got=%h want=cafef00d", rd);
    end
    xact(1, 0, 2'b10, 0, 32'h0, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b0, 32'h5A5A5A5A}) begin
      bad++; $display("FAIL err_word0 got=%h want=5a5a5a5a", rd);
    end
  endtask

  task automatic test_latency3;
    logic [31:0] rd; logic er; int lat;
    @(posedge clk); #1;
    req_we = 0; req_size = 2'b10; req_addr = 32'h0; v3 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy3 !== 1'b1) begin
      bad++; $display("FAIL l3_ready_t got=%b want=1", rdy3);
    end
    @(posedge clk); #1;
    req_we = 1; req_addr = 32'h4; req_wdata = 32'h77;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if ({rdy3, rv3} !== 2'b00) begin
        bad++; $display("FAIL l3_wait_%0d got=%b want=00", c, {rdy3, rv3});
      end
    end
    @(negedge clk);
    total++;
    if ({rdy3, rv3, err3, rd3} !== {3'b110, 32'h0}) begin
      bad++;
      $display("FAIL l3_resp got=%b_%h want=110_00000000",
               {rdy3, rv3, err3}, rd3);
    end
    @(posedge clk); #1 v3 = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy3, rv3} !== 2'b00) begin
      bad++; $display("FAIL l3_second_accept got=%b want=00", {rdy3, rv3});
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({rv3, err3} !== 2'b10) begin
      bad++; $display("FAIL l3_second_resp got=%b want=10", {rv3, err3});
    end
    xact(3, 0, 2'b10, 0, 32'h4, 0, rd, er, lat);
    total++;
    if ({lat, rd} !== {32'd3, 32'h77}) begin
      bad++; $display("FAIL l3_lw got lat=%0d d=%h want lat=3 d=77", lat, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 4; i++)
      xact(1, 1, 2'b10, 0, 32'h20 + 4 * i, 32'hA0 + i, rd, er, lat);
    @(posedge clk); #1;
    sel = 1; req_we = 0; req_size = 2'b10; v1 = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) req_addr = 32'h20 + 4 * i;
      else v1 = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({rv1, rd1} !== {1'b1, 32'hA0 + i - 1}) begin
          bad++;
          $display("FAIL b2b_%0d got=%b_%h want=1_%h",
                   i - 1, rv1, rd1, 32'hA0 + i - 1);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_wait;
    int n;
    logic seen;
    logic [31:0] rd; logic er; int lat;
    @(posedge clk); #1;
    req_we = 0; req_size = 2'b10; req_addr = 32'h4; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n = 0; seen = 1'b0;
    @(negedge clk);
    while (!rdy3 && n < 100) begin
      if (rv3) seen = 1'b1;
      n++;
      @(negedge clk);
    end
    total++;
    if ({seen, rv3} !== 2'b00) begin
      bad++; $display("FAIL rst_wait_resp got=%b want=00", {seen, rv3});
    end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL rst_wait_clear got=%0d want=16", n);
    end
    xact(3, 0, 2'b10, 0, 32'h4, 0, rd, er, lat);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("FAIL rst_recleared3 got=%h want=00000000", rd);
    end
    xact(1, 0, 2'b10, 0, 32'h8, 0, rd, er, lat);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("FAIL rst_recleared1 got=%h want=00000000", rd);
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_errors;
    test_latency3;
    test_back_to_back;
    test_reset_in_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
